// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared widths, types and helpers for the 7-segment scan controller
package seg_scan_pkg;

  // Width of one BCD digit as seen by the shared decoder
  localparam int DIG_W = 4;

  typedef logic [DIG_W-1:0] digit_t;

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int seg_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// rtl/seg_scan_ctrl_prescaler.sv - per-digit slot counter with end-of-slot and blank-gap flags
module scan_prescaler
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = seg_clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic slot_end_o,
  output logic blank_nxt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign slot_end_o = (r_cnt == CNT_LAST);

  // Next count: clear wins, otherwise run 0..CLK_DIV-1 and wrap
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_i) begin
      w_cnt_nxt = '0;
    end else if (en_i) begin
      w_cnt_nxt = slot_end_o ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // The parent registers its outputs on the same edge as the count, so it
  // needs to know whether the count it is moving to lies in the dark gap
  assign blank_nxt_o = (w_cnt_nxt < CNT_BLANK);

  // Slot counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan controller driving one shared BCD-to-7-seg decoder
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG         = 6,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [DIG_W*NDIG-1:0] digits_i,
  input  logic [NDIG-1:0]       blink_mask_i,
  input  logic                  lz_en_i,
  output logic [DIG_W-1:0]      dig_o,
  output logic                  dec_en_o,
  output logic [NDIG-1:0]       an_n_o,
  output logic                  frame_o,
  output logic                  blink_ph_o
);

  localparam int CNT_W = seg_clog2(CLK_DIV);
  localparam int IDX_W = seg_clog2(NDIG);
  localparam int FC_W  = seg_clog2(BLINK_FRAMES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  // Scan state
  logic                  r_run;
  logic [IDX_W-1:0]      r_idx;
  logic [DIG_W*NDIG-1:0] r_snap_dig;
  logic [NDIG-1:0]       r_snap_mask;
  logic                  r_snap_lz;
  logic [FC_W-1:0]       r_fcnt;
  logic                  r_blink_ph;

  // Output flops
  logic [DIG_W-1:0]      r_dig;
  logic                  r_dec_en;
  logic [NDIG-1:0]       r_an_n;
  logic                  r_frame;

  // Next-state and decode nets
  logic                  w_slot_end;
  logic                  w_blank_nxt;
  logic                  w_restart;
  logic                  w_frame_wrap;
  logic                  w_frame_start;
  logic                  w_clr;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DIG_W*NDIG-1:0] w_snap_dig_nxt;
  logic [NDIG-1:0]       w_snap_mask_nxt;
  logic                  w_snap_lz_nxt;
  logic [FC_W-1:0]       w_fcnt_nxt;
  logic                  w_ph_nxt;
  digit_t                w_dig_arr [NDIG];
  digit_t                w_dig_nxt;
  logic                  w_sup_nxt;
  logic                  w_show_nxt;

  // A cleared counter means either idle (en_i low) or the first enabled
  // cycle after idle/reset, which always restarts at a frame boundary
  assign w_restart     = en_i & ~r_run;
  assign w_frame_wrap  = en_i & r_run & w_slot_end & (r_idx == IDX_LAST);
  assign w_frame_start = w_restart | w_frame_wrap;
  assign w_clr         = ~en_i | ~r_run;

  scan_prescaler #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .clr_i       (w_clr),
    .slot_end_o  (w_slot_end),
    .blank_nxt_o (w_blank_nxt)
  );

  // Inputs are only sampled at a frame start so a frame never tears
  assign w_snap_dig_nxt  = w_frame_start ? digits_i     : r_snap_dig;
  assign w_snap_mask_nxt = w_frame_start ? blink_mask_i : r_snap_mask;
  assign w_snap_lz_nxt   = w_frame_start ? lz_en_i      : r_snap_lz;

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    assign w_dig_arr[k] = w_snap_dig_nxt[DIG_W*k +: DIG_W];
  end

  // Digit index and blink phase for the cycle being entered
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_clr) begin
      w_idx_nxt = '0;
    end else if (w_slot_end) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end

    w_fcnt_nxt = r_fcnt;
    w_ph_nxt   = r_blink_ph;
    if (w_frame_wrap) begin
      if (r_fcnt == FC_LAST) begin
        w_fcnt_nxt = '0;
        w_ph_nxt   = ~r_blink_ph;
      end else begin
        w_fcnt_nxt = r_fcnt + FC_W'(1);
      end
    end
  end

  // Suppression and lit decision for the cycle being entered
  always_comb begin
    w_dig_nxt  = w_dig_arr[w_idx_nxt];
    w_sup_nxt  = ((w_idx_nxt == IDX_LAST) && w_snap_lz_nxt && (w_dig_nxt == '0)) ||
                 (w_snap_mask_nxt[w_idx_nxt] && w_ph_nxt);
    w_show_nxt = ~w_blank_nxt & ~w_sup_nxt;
  end

  // Scan state registers; frame counter and blink phase hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_idx       <= '0;
      r_snap_dig  <= '0;
      r_snap_mask <= '0;
      r_snap_lz   <= 1'b0;
      r_fcnt      <= '0;
      r_blink_ph  <= 1'b0;
    end else begin
      r_run       <= en_i;
      r_idx       <= w_idx_nxt;
      r_snap_dig  <= w_snap_dig_nxt;
      r_snap_mask <= w_snap_mask_nxt;
      r_snap_lz   <= w_snap_lz_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_blink_ph  <= w_ph_nxt;
    end
  end

  // Output flops track the slot state entered on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig    <= '0;
      r_dec_en <= 1'b0;
      r_an_n   <= '1;
      r_frame  <= 1'b0;
    end else if (!en_i) begin
      r_dig    <= '0;
      r_dec_en <= 1'b0;
      r_an_n   <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_dig    <= w_dig_nxt;
      r_dec_en <= w_show_nxt;
      r_an_n   <= w_show_nxt ? ~(NDIG'(1) << w_idx_nxt) : '1;
      r_frame  <= w_frame_start;
    end
  end

  assign dig_o      = r_dig;
  assign dec_en_o   = r_dec_en;
  assign an_n_o     = r_an_n;
  assign frame_o    = r_frame;
  assign blink_ph_o = r_blink_ph;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl with directed expected values
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic [15:0] digits_i;
  logic [3:0]  blink_mask_i;
  logic        lz_en_i;
  logic [3:0]  dig_o;
  logic        dec_en_o;
  logic [3:0]  an_n_o;
  logic        frame_o;
  logic        blink_ph_o;

  seg_scan_ctrl #(
    .NDIG         (4),
    .CLK_DIV      (8),
    .BLANK_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .digits_i     (digits_i),
    .blink_mask_i (blink_mask_i),
    .lz_en_i      (lz_en_i),
    .dig_o        (dig_o),
    .dec_en_o     (dec_en_o),
    .an_n_o       (an_n_o),
    .frame_o      (frame_o),
    .blink_ph_o   (blink_ph_o)
  );

  typedef struct packed {
    int         at;
    logic [3:0] dig;
    logic       en;
    logic [3:0] an;
    logic       fr;
    logic       ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_edge = 0;
  int   base   = 0;
  int   total  = 0;
  int   bad    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) n_edge = n_edge + 1;

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got dig=%h en=%b an=%b fr=%b ph=%b, want dig=%h en=%b an=%b fr=%b ph=%b",
               name, act[10:7], act[6], act[5:2], act[1], act[0],
               req[10:7], req[6], req[5:2], req[1], req[0]);
    end
  endtask

  task automatic ex(input int k, input logic [3:0] d, input logic e, input logic [3:0] a,
                    input logic f, input logic p);
    exp_t x;
    x.at  = base + k;
    x.dig = d;
    x.en  = e;
    x.an  = a;
    x.fr  = f;
    x.ph  = p;
    exp_q.push_back(x);
  endtask

  task automatic wait_to(input int k);
    while (n_edge < base + k) @(negedge clk);
  endtask

  // Monitor: pops expectations as the DUT reaches their cycle
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].at <= n_edge) begin
      e = exp_q.pop_front();
      if (e.at < n_edge) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL missed cyc%0d: got none, want check at edge %0d", e.at - base, e.at);
      end else begin
        chk($sformatf("cyc%0d", e.at - base),
            {dig_o, dec_en_o, an_n_o, frame_o, blink_ph_o},
            {e.dig, e.en, e.an, e.fr, e.ph});
      end
    end
  end

  initial begin
    #100000;
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n        = 1'b0;
    en_i         = 1'b0;
    digits_i     = 16'h1234;
    blink_mask_i = 4'b0000;
    lz_en_i      = 1'b0;
    ex(1, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en_i  = 1'b1;
    base  = n_edge + 1;

    // Frame A: 1234, plain scan
    ex(0,  4'h4, 1'b0, 4'hF, 1'b1, 1'b0);
    ex(1,  4'h4, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(2,  4'h4, 1'b1, 4'hE, 1'b0, 1'b0);
    ex(7,  4'h4, 1'b1, 4'hE, 1'b0, 1'b0);
    ex(8,  4'h3, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(10, 4'h3, 1'b1, 4'hD, 1'b0, 1'b0);
    ex(18, 4'h2, 1'b1, 4'hB, 1'b0, 1'b0);
    ex(24, 4'h1, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(26, 4'h1, 1'b1, 4'h7, 1'b0, 1'b0);
    ex(31, 4'h1, 1'b1, 4'h7, 1'b0, 1'b0);
    wait_to(10);
    digits_i = 16'h5678;

    // Frame B: new digits only now
    ex(32, 4'h8, 1'b0, 4'hF, 1'b1, 1'b0);
    ex(33, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(34, 4'h8, 1'b1, 4'hE, 1'b0, 1'b0);
    ex(42, 4'h7, 1'b1, 4'hD, 1'b0, 1'b0);
    ex(50, 4'h6, 1'b1, 4'hB, 1'b0, 1'b0);
    ex(58, 4'h5, 1'b1, 4'h7, 1'b0, 1'b0);
    ex(63, 4'h5, 1'b1, 4'h7, 1'b0, 1'b0);
    wait_to(40);
    blink_mask_i = 4'b0011;

    // Frame C: blink phase rises, slots 0-1 dark
    ex(64, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1);
    ex(66, 4'h8, 1'b0, 4'hF, 1'b0, 1'b1);
    ex(74, 4'h7, 1'b0, 4'hF, 1'b0, 1'b1);
    ex(82, 4'h6, 1'b1, 4'hB, 1'b0, 1'b1);
    ex(90, 4'h5, 1'b1, 4'h7, 1'b0, 1'b1);
    wait_to(70);
    blink_mask_i = 4'b0000;
    digits_i     = 16'h0959;
    lz_en_i      = 1'b1;

    // Frame D: leading zero blanks slot 3
    ex(96,  4'h9, 1'b0, 4'hF, 1'b1, 1'b1);
    ex(98,  4'h9, 1'b1, 4'hE, 1'b0, 1'b1);
    ex(106, 4'h5, 1'b1, 4'hD, 1'b0, 1'b1);
    ex(114, 4'h9, 1'b1, 4'hB, 1'b0, 1'b1);
    ex(120, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1);
    ex(122, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1);
    ex(127, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1);
    wait_to(100);
    digits_i = 16'h1959;

    // Frame E: slot 3 lit again, blink phase falls
    ex(128, 4'h9, 1'b0, 4'hF, 1'b1, 1'b0);
    ex(130, 4'h9, 1'b1, 4'hE, 1'b0, 1'b0);
    ex(146, 4'h9, 1'b1, 4'hB, 1'b0, 1'b0);
    ex(154, 4'h1, 1'b1, 4'h7, 1'b0, 1'b0);
    wait_to(130);
    digits_i = 16'hF0C0;

    // Frame F: low zeros and 10..15 shown; en_i drop at 13, restart at 18
    ex(160, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0);
    ex(162, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0);
    ex(170, 4'hC, 1'b1, 4'hD, 1'b0, 1'b0);
    ex(173, 4'hC, 1'b1, 4'hD, 1'b0, 1'b0);
    ex(174, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(176, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(178, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0);
    ex(180, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0);
    ex(186, 4'hC, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(188, 4'hC, 1'b1, 4'hD, 1'b0, 1'b0);
    ex(209, 4'hF, 1'b1, 4'h7, 1'b0, 1'b0);
    ex(210, 4'h0, 1'b0, 4'hF, 1'b1, 1'b1);
    ex(214, 4'h0, 1'b1, 4'hE, 1'b0, 1'b1);
    ex(215, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0);
    ex(216, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0);
    ex(218, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0);
    wait_to(173);
    en_i = 1'b0;
    wait_to(177);
    en_i = 1'b1;

    // Asynchronous reset mid-slot
    wait_to(214);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {dig_o, dec_en_o, an_n_o, frame_o, blink_ph_o},
        {4'h0, 1'b0, 4'hF, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    wait_to(220);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
